bram_rd_2_axi_wdata: RTL
========================

# bram_rd_2_axi_wdata

Reverse of the AXI-read-to-BRAM-write path. Reads 64-bit words from a BRAM read port, splits each into two 32-bit beats, and drives them onto an AXI4-FULL Write Data channel in WLAST-delimited bursts. Sits between the frame/game-state BRAM and the AXI master that writes results back to DDR. The master owns the AW channel; this block owns W only.

## Interface
- `TOTAL_NUM`, 1536: 32-bit beats per stage; must be even.
- `BURST_LEN`, 256: beats per AXI burst; power of 2.
- `ADDR_W`, 14: BRAM address width.
- `axi_ACLK` in 1: the single clock.
- `axi_ARESET` in 1: synchronous, active-high reset.
- `stage_start` in 1: level; rising edge starts a stage, low aborts.
- `bram_enb` out 1: BRAM read enable.
- `bram_addrb` out ADDR_W: BRAM word address.
- `bram_doutb` in 64: BRAM read data.
- `axi_WDATA` out 32: write data.
- `axi_WSTRB` out 4: constant 4'hF.
- `axi_WLAST` out 1: last beat of burst.
- `axi_WVALID` out 1: write valid.
- `axi_WREADY` in 1: write ready.
- `bram_rdone` out 1: stage complete; sticky until next start.

## Operation
- `init` = stage_start & ~start_ff, where start_ff is stage_start registered.
- `init` clears all counters, flushes the FIFO, clears bram_rdone, and sets state to RUN.
- States:
  - IDLE: after reset.
  - RUN
  - DRAIN: abort.
  - DONE
- RUN → DONE on the handshake of beat TOTAL_NUM-1.
- RUN → DRAIN when stage_start goes low.
- DRAIN → IDLE once no W beat is pending.
- DONE → RUN on `init`.
- `init` from any state restarts the stage, except in DRAIN with WVALID high. In that case `init` is deferred until the pending beat is handshaken.
- Prefetch:
  - Issue a read (bram_enb=1, bram_addrb=rd_addr, rd_addr++) when state is RUN and rd_addr < TOTAL_NUM/2 and in-flight + occupancy < 4.
  - rd_addr stops at TOTAL_NUM/2; it does not wrap.
- Read data is written into a 4×64 FIFO when the read-latency pipeline emits valid data.
- Serializer:
  - The FIFO head's bits[31:0] are beat 2k, then bits[63:32] are beat 2k+1.
  - The FIFO pops on the handshake of the high half.
- WLAST = (beat_cnt[log2(BURST_LEN)-1:0] == BURST_LEN-1) | (beat_cnt == TOTAL_NUM-1).
- beat_cnt increments only on WVALID & WREADY.
- Once WVALID is high, WDATA, WLAST and WVALID stay stable until WREADY. The block never drops WVALID without a handshake.
- DRAIN:
  - No new reads.
  - In-flight read data is discarded.
  - The pending beat completes, then the FIFO is flushed.
  - bram_rdone stays 0.
- bram_rdone goes to 1 the cycle after the final handshake.

## Timing
- Reset values:
  - WVALID, WLAST, WDATA, bram_enb, bram_addrb: 0.
  - bram_rdone: 0.
  - state: IDLE.
  - FIFO: empty.
- BRAM read latency is 1 cycle.
- `init` is seen in cycle N. First bram_enb=1 (addr 0) is in N+1. Data is captured at end of N+2. First WVALID is in N+3.
- Sustained rate is one beat per cycle while WREADY is held high: one BRAM read every 2 cycles, and the FIFO never runs dry.
- WREADY low: the FIFO fills to 4 entries plus 0 in flight, then reads stall. No data is lost.
- `init` and the last handshake in the same cycle: `init` wins. bram_rdone stays 0 and the counters clear.
- Reset asserted mid-burst: all outputs return to reset values on the next edge, WVALID included.

## Configuration
- `BR2AW_BRAM_OREG_EN`:
  - Defined: the BRAM output register is enabled and read latency is 2 cycles. The latency pipeline gains one stage, the credit check counts up to 2 in flight, and first WVALID moves to N+4. Sustained rate is unchanged.
  - Undefined: 1-cycle latency as above.

## Structure
- Shared package `axi_bram_pkg` holds:
  - `AXI_DW`=32.
  - `BRAM_DW`=64.
  - `BRAM_RD_LAT` (derived from the macro).
  - the state enum {IDLE, RUN, DRAIN, DONE}.
  - `FIFO_DEPTH`=4.
- Sub-module `br2aw_fifo` is a 4×64 synchronous FIFO with flush, full, empty and count outputs.
- The top level holds the FSM, prefetch/credit logic, serializer, and the beat/WLAST counters.

## Test plan
- TOTAL_NUM=1536, BURST_LEN=256, WREADY tied 1, BRAM[i]={hi=2i+1, lo=2i}:
  - WDATA sequence 0..1535, consecutive.
  - WLAST on beats 255, 511, … 1535.
  - bram_rdone=1 one cycle after beat 1535.
  - First WVALID at N+3 (N+4 with macro).
- Random WREADY at 30% duty:
  - Same data order, no duplicates or drops.
  - WDATA and WLAST stable while WVALID & ~WREADY.
  - bram_enb never issued when count + in-flight = 4.
- TOTAL_NUM=6, BURST_LEN=4: WLAST on beats 3 and 5; exactly 3 BRAM reads.
- stage_start low after beat 100 with WREADY held low 5 cycles:
  - Beat 101 holds until WREADY, then WVALID=0.
  - bram_rdone stays 0.
  - A new `init` restarts at beat 0, addr 0.
- axi_ARESET pulsed high mid-burst with WVALID=1: next cycle all outputs are 0, state is IDLE, FIFO is empty.

Source files
------------

// File: rtl/axi_bram_pkg.sv
// Shared constants and FSM state type for the BRAM-to-AXI-W path.
// Macro BR2AW_BRAM_OREG_EN selects a 2-cycle BRAM read latency.
package axi_bram_pkg;
  localparam int AXI_DW = 32;
  localparam int BRAM_DW = 64;
`ifdef BR2AW_BRAM_OREG_EN
  localparam int BRAM_RD_LAT = 2;
`else
  localparam int BRAM_RD_LAT = 1;
`endif
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/bram_rd_2_axi_wdata_if.sv
// AXI4 write-data channel bundle.
// master: WDATA/WSTRB/WLAST/WVALID out, WREADY in; slave: mirror.
interface bram_rd_2_axi_wdata_if;
  logic [axi_bram_pkg::AXI_DW-1:0] axi_WDATA;
  logic [3:0] axi_WSTRB;
  logic axi_WLAST;
  logic axi_WVALID;
  logic axi_WREADY;

  modport master (
    output axi_WDATA, axi_WSTRB,
    output axi_WLAST, axi_WVALID,
    input  axi_WREADY
  );

  modport slave (
    input  axi_WDATA, axi_WSTRB,
    input  axi_WLAST, axi_WVALID,
    output axi_WREADY
  );
endinterface

// File: rtl/br2aw_fifo.sv
// 4x64 synchronous FIFO with flush and occupancy count.
// Ports: clk_i/rst_i, flush_i, wr_i/wdata_i, rd_i/rdata_o, full_o, empty_o, count_o.
module br2aw_fifo
  import axi_bram_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               wr_i,
  input  logic [BRAM_DW-1:0] wdata_i,
  input  logic               rd_i,
  output logic [BRAM_DW-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_CW-1:0] count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [BRAM_DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [FIFO_CW-1:0] cnt_q;
  logic wr, rd;

  assign full_o  = cnt_q == FIFO_CW'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rp_q];
  assign wr = wr_i & ~full_o;
  assign rd = rd_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + PW'(1);
      if (rd) rp_q <= rp_q + PW'(1);
      unique case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + FIFO_CW'(1);
        2'b01:   cnt_q <= cnt_q - FIFO_CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/bram_rd_2_axi_wdata.sv
// Streams 64-bit BRAM words as 32-bit AXI W beats (lo then hi half).
// Ports: axi_ACLK/axi_ARESET, stage_start, bram_* read port, bram_rdone, w (W channel master).
// Macro BR2AW_BRAM_OREG_EN: 2-cycle BRAM read latency.
module bram_rd_2_axi_wdata
  import axi_bram_pkg::*;
#(
  parameter int TOTAL_NUM = 1536,
  parameter int BURST_LEN = 256,
  parameter int ADDR_W    = 14
) (
  input  logic               axi_ACLK,
  input  logic               axi_ARESET,
  input  logic               stage_start,
  output logic               bram_enb,
  output logic [ADDR_W-1:0]  bram_addrb,
  input  logic [BRAM_DW-1:0] bram_doutb,
  output logic               bram_rdone,
  bram_rd_2_axi_wdata_if.master w
);
  localparam int BW = $clog2(TOTAL_NUM + 1);
  localparam int LB = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] HALF =
    (ADDR_W + 1)'(TOTAL_NUM / 2);

  state_e state_q;
  logic start_q, init_pend_q, drain_pend_q;
  logic half_q, rdone_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [BRAM_RD_LAT-1:0] vld_q;
  logic [BW-1:0] beat_q;

  logic init_raw, defer, init_go, run;
  logic issue, wvalid, hs, last_beat;
  logic fifo_wr, fifo_rd, fifo_flush;
  logic fifo_full, fifo_empty;
  logic [FIFO_CW-1:0] fifo_cnt, infl;
  logic [BRAM_DW-1:0] head;

  assign run      = state_q == RUN;
  assign init_raw = stage_start & ~start_q;
  // A restart may not cut a beat that is already on the bus.
  assign defer    = (state_q == DRAIN) & drain_pend_q;
  assign init_go  = (init_raw | init_pend_q) & ~defer;

  // Credit: reads in flight plus stored words never exceed the FIFO.
  assign infl  = FIFO_CW'($countones(vld_q));
  assign issue = run & ~init_go
               & ({1'b0, rd_addr_q} < HALF)
               & ((fifo_cnt + infl) < FIFO_CW'(FIFO_DEPTH));

  assign wvalid = (run & ~fifo_empty)
                | ((state_q == DRAIN) & drain_pend_q);
  assign hs        = wvalid & w.axi_WREADY;
  assign last_beat = beat_q == BW'(TOTAL_NUM - 1);

  assign fifo_wr    = vld_q[BRAM_RD_LAT-1] & run & ~fifo_full;
  assign fifo_rd    = hs & half_q;
  assign fifo_flush = init_go
                    | ((state_q == DRAIN)
                       & (~drain_pend_q | w.axi_WREADY));

  assign bram_enb   = issue;
  assign bram_addrb = issue ? rd_addr_q : '0;
  assign bram_rdone = rdone_q;

  assign w.axi_WSTRB  = 4'hF;
  assign w.axi_WVALID = wvalid;
  assign w.axi_WDATA  = !wvalid ? '0
                      : half_q ? head[63:32] : head[31:0];
  assign w.axi_WLAST  = wvalid
    & ((beat_q[LB-1:0] == LB'(BURST_LEN - 1)) | last_beat);

  br2aw_fifo u_fifo (
    .clk_i   (axi_ACLK),
    .rst_i   (axi_ARESET),
    .flush_i (fifo_flush),
    .wr_i    (fifo_wr),
    .wdata_i (bram_doutb),
    .rd_i    (fifo_rd),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      init_pend_q  <= 1'b0;
      drain_pend_q <= 1'b0;
      half_q       <= 1'b0;
      rdone_q      <= 1'b0;
      rd_addr_q    <= '0;
      vld_q        <= '0;
      beat_q       <= '0;
    end else begin
      start_q <= stage_start;
      vld_q   <= BRAM_RD_LAT'({vld_q, issue});
      if (issue) rd_addr_q <= rd_addr_q + ADDR_W'(1);
      if (hs) begin
        beat_q <= beat_q + BW'(1);
        half_q <= ~half_q;
      end
      if (init_raw && defer) init_pend_q <= 1'b1;
      unique case (state_q)
        RUN: begin
          if (hs && last_beat) begin
            state_q <= DONE;
            rdone_q <= 1'b1;
          end else if (!stage_start) begin
            state_q      <= DRAIN;
            drain_pend_q <= wvalid & ~w.axi_WREADY;
          end
        end
        DRAIN: begin
          if (!drain_pend_q || w.axi_WREADY) begin
            state_q      <= IDLE;
            drain_pend_q <= 1'b0;
          end
        end
        IDLE, DONE: begin
        end
      endcase
      if (init_go) begin
        state_q      <= RUN;
        init_pend_q  <= 1'b0;
        drain_pend_q <= 1'b0;
        half_q       <= 1'b0;
        rdone_q      <= 1'b0;
        rd_addr_q    <= '0;
        vld_q        <= '0;
        beat_q       <= '0;
      end
    end
  end
endmodule
